fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the IF/ID pipeline register. Holds the PC and drives a request/acknowledge instruction-memory port tolerant of multi-cycle latency. Applies branch/jump redirects and hazard-unit stalls. Presents `instruction_IF` / `PC_sumado_IF` to IF/ID, with a NOP (all-zero) bubble whenever no fetched instruction is available.

---
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Request/acknowledge instruction-memory port between the fetch stage and the
// instruction memory. Latency is arbitrary: the requester holds imem_req and
// imem_addr steady until the memory returns imem_ack together with the word.
//
// Signals
//   imem_req    requester -> memory  fetch request, held until acknowledged
//   imem_addr   requester -> memory  word-aligned fetch address
//   imem_ack    memory -> requester  imem_rdata valid this cycle
//   imem_rdata  memory -> requester  instruction word
//
// Modports
//   master  the fetch stage (drives request/address)
//   slave   the instruction memory (drives ack/data)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register. Holds the PC,
// issues requests on a multi-cycle-tolerant instruction-memory port, applies
// jump/branch redirects and hazard-unit stalls, and presents either a fetched
// instruction or an all-zero NOP bubble to IF/ID.
//
// Parameters
//   RESET_PC          PC loaded on reset (low two bits are forced to zero)
//
// Ports
//   clk               single clock, rising edge
//   reset             synchronous, active-high
//   i_pc_write        hazard unit: 0 holds the presented instruction
//   i_pcsrc           branch taken (one-cycle pulse)
//   i_branch_target   branch destination, valid with i_pcsrc
//   i_jump            jump taken (one-cycle pulse), wins over i_pcsrc
//   i_jump_target     jump destination, valid with i_jump
//   imem              instruction-memory port (master side)
//   o_instruction_if  instruction to IF/ID, zero when o_fetch_valid = 0
//   o_pc_sumado_if    PC+4 of the presented instruction, zero when invalid
//   o_fetch_valid     o_instruction_if carries a real instruction this cycle
//
// Outputs are combinational from the state registers plus the memory
// response, i_pc_write and the redirect inputs, so a zero-wait memory yields
// one instruction per cycle through the bypass path. imem_req depends only on
// state and reset, never on i_pc_write.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pc_write,
    input  logic                 i_pcsrc,
    input  logic [31:0]          i_branch_target,
    input  logic                 i_jump,
    input  logic [31:0]          i_jump_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          o_instruction_if,
    output logic [31:0]          o_pc_sumado_if,
    output logic                 o_fetch_valid
);

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        align_word = addr & 32'hFFFF_FFFC;
    endfunction

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    // FETCH: a request is outstanding at r_pc.
    // READY: the word for r_pc sits in r_inst_buf waiting for a stall to end.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst_buf;
    logic [31:0] w_inst_buf_nxt;
    logic        r_redir_pend;
    logic        w_redir_pend_nxt;
    logic [31:0] r_redir_pc;
    logic [31:0] w_redir_pc_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc_sumado;
    logic        w_valid;

    assign w_redirect = i_jump | i_pcsrc;
    // Jump outranks a simultaneous branch.
    assign w_target   = i_jump ? align_word(i_jump_target)
                               : align_word(i_branch_target);
    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state and output decode for the fetch FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_buf_nxt   = r_inst_buf;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        w_req            = 1'b0;
        w_addr           = r_pc;
        w_instr          = 32'h0000_0000;
        w_pc_sumado      = 32'h0000_0000;
        w_valid          = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (imem.imem_ack) begin
                    if (r_redir_pend || w_redirect) begin
                        // The returning word belongs to the abandoned path:
                        // drop it and restart at the newest target.
                        w_pc_nxt         = w_redirect ? w_target : r_redir_pc;
                        w_redir_pend_nxt = 1'b0;
                    end else if (i_pc_write) begin
                        // Bypass: hand the word straight to IF/ID.
                        w_instr     = imem.imem_rdata;
                        w_pc_sumado = w_pc_plus4;
                        w_valid     = 1'b1;
                        w_pc_nxt    = w_pc_plus4;
                    end else begin
                        // Stalled: park the word and stop requesting.
                        w_inst_buf_nxt = imem.imem_rdata;
                        w_state_nxt    = ST_READY;
                    end
                end else begin
                    if (w_redirect) begin
                        // The request address must stay stable until the ack,
                        // so remember the target and apply it afterwards.
                        w_redir_pend_nxt = 1'b1;
                        w_redir_pc_nxt   = w_target;
                    end else begin
                        w_redir_pend_nxt = r_redir_pend;
                    end
                end
            end

            ST_READY: begin
                w_instr     = r_inst_buf;
                w_pc_sumado = w_pc_plus4;
                w_valid     = 1'b1;
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (i_pc_write) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_READY;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // While in reset the port is idle and IF/ID sees a bubble.
        if (reset) begin
            w_req       = 1'b0;
            w_addr      = RESET_PC_ALIGNED;
            w_instr     = 32'h0000_0000;
            w_pc_sumado = 32'h0000_0000;
            w_valid     = 1'b0;
        end else begin
            w_req       = w_req;
        end
    end

    // State registers; reset has priority so an ack during reset is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC_ALIGNED;
            r_inst_buf   <= 32'h0000_0000;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst_buf   <= w_inst_buf_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
        end
    end

    assign imem.imem_req    = w_req;
    assign imem.imem_addr   = w_addr;
    assign o_instruction_if = w_instr;
    assign o_pc_sumado_if   = w_pc_sumado;
    assign o_fetch_valid    = w_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with RESET_PC = 0x100. The memory model
// returns 0xA0 + address after a programmable number of wait cycles; inputs
// change on the falling edge and outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instruction_if;
    logic [31:0] pc_sumado_if;
    logic        fetch_valid;

    int          wait_cycles;
    logic        force_ack;
    int          wait_cnt;
    int          n_checks;
    int          n_fail;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_pc_write       (pc_write),
        .i_pcsrc          (pcsrc),
        .i_branch_target  (branch_target),
        .i_jump           (jump),
        .i_jump_target    (jump_target),
        .imem             (imem),
        .o_instruction_if (instruction_if),
        .o_pc_sumado_if   (pc_sumado_if),
        .o_fetch_valid    (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack once the request has waited wait_cycles cycles.
    assign imem.imem_ack   = (imem.imem_req && (wait_cnt >= wait_cycles)) || force_ack;
    assign imem.imem_rdata = 32'h0000_00A0 + imem.imem_addr;

    always @(posedge clk) begin
        if (imem.imem_req && !imem.imem_ack) wait_cnt <= wait_cnt + 1;
        else                                 wait_cnt <= 0;
    end

    task automatic apply_reset(input int waits);
        @(negedge clk);
        reset = 1'b1; pc_write = 1'b1; pcsrc = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; force_ack = 1'b0;
        wait_cycles = waits;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; pc_write = 1'b1; pcsrc = 1'b0; jump = 1'b0;
        wait_cycles = 0; force_ack = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem.imem_req); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
        n_checks++; if (instruction_if !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instruction_if); end
        n_checks++; if (pc_sumado_if !== 32'h0) begin n_fail++; $display("FAIL reset_pcs: got %h expected 0", pc_sumado_if); end
        n_checks++; if (imem.imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h expected 100", imem.imem_addr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (imem.imem_addr !== 32'h100 + 32'(4*k)) begin n_fail++; $display("FAIL zw_addr[%0d]: got %h expected %h", k, imem.imem_addr, 32'h100 + 32'(4*k)); end
            n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d]: got %b expected 1", k, fetch_valid); end
            n_checks++; if (pc_sumado_if !== 32'h104 + 32'(4*k)) begin n_fail++; $display("FAIL zw_pcs[%0d]: got %h expected %h", k, pc_sumado_if, 32'h104 + 32'(4*k)); end
            n_checks++; if (instruction_if !== 32'h1A0 + 32'(4*k)) begin n_fail++; $display("FAIL zw_instr[%0d]: got %h expected %h", k, instruction_if, 32'h1A0 + 32'(4*k)); end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_states();
        apply_reset(2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                #1;
                n_checks++; if (imem.imem_addr !== 32'h100 + 32'(4*r)) begin n_fail++; $display("FAIL ws_addr[%0d.%0d]: got %h expected %h", r, c, imem.imem_addr, 32'h100 + 32'(4*r)); end
                n_checks++; if (fetch_valid !== (c == 2)) begin n_fail++; $display("FAIL ws_valid[%0d.%0d]: got %b expected %b", r, c, fetch_valid, (c == 2)); end
                if (c == 2) begin
                    n_checks++; if (instruction_if !== 32'h1A0 + 32'(4*r)) begin n_fail++; $display("FAIL ws_instr[%0d]: got %h expected %h", r, instruction_if, 32'h1A0 + 32'(4*r)); end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset(0);
        repeat (2) @(negedge clk);       // 0x100, 0x104 consumed
        pc_write = 1'b0;                 // word at 0x108 arrives while stalled
        #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_capture_valid: got %b expected 0", fetch_valid); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", c, imem.imem_req); end
            n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, fetch_valid); end
            n_checks++; if (instruction_if !== 32'h1A8) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h expected 1a8", c, instruction_if); end
            n_checks++; if (pc_sumado_if !== 32'h10C) begin n_fail++; $display("FAIL stall_pcs[%0d]: got %h expected 10c", c, pc_sumado_if); end
        end
        @(negedge clk);
        pc_write = 1'b1; #1;
        n_checks++; if (instruction_if !== 32'h1A8) begin n_fail++; $display("FAIL stall_release_instr: got %h expected 1a8", instruction_if); end
        @(negedge clk); #1;
        n_checks++; if (imem.imem_addr !== 32'h10C || imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_next_addr: got %h req %b expected 10c req 1", imem.imem_addr, imem.imem_req); end
        n_checks++; if (instruction_if !== 32'h1AC) begin n_fail++; $display("FAIL stall_next_instr: got %h expected 1ac", instruction_if); end
        @(negedge clk);
    endtask

    task automatic test_redirect_pending();
        apply_reset(0);
        repeat (4) @(negedge clk);       // now requesting 0x110
        wait_cycles = 2; pcsrc = 1'b1; branch_target = 32'h200; #1;
        n_checks++; if (imem.imem_addr !== 32'h110 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rp_pulse: addr %h valid %b expected 110 0", imem.imem_addr, fetch_valid); end
        @(negedge clk);
        pcsrc = 1'b0; #1;
        n_checks++; if (imem.imem_addr !== 32'h110) begin n_fail++; $display("FAIL rp_addr_stable: got %h expected 110", imem.imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (imem.imem_ack !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rp_discard: ack %b valid %b expected 1 0", imem.imem_ack, fetch_valid); end
        @(negedge clk); #1;
        n_checks++; if (imem.imem_addr !== 32'h200 || imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL rp_target_addr: got %h req %b expected 200 1", imem.imem_addr, imem.imem_req); end
        @(negedge clk);
        wait_cycles = 0; #1;
        n_checks++; if (instruction_if !== 32'h2A0 || pc_sumado_if !== 32'h204 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rp_target_instr: got %h/%h/%b expected 2a0/204/1", instruction_if, pc_sumado_if, fetch_valid); end
        @(negedge clk);
    endtask

    task automatic test_newest_wins();
        apply_reset(2);
        pcsrc = 1'b1; branch_target = 32'h400;
        @(negedge clk);
        pcsrc = 1'b0; jump = 1'b1; jump_target = 32'h500; #1;
        n_checks++; if (imem.imem_addr !== 32'h100) begin n_fail++; $display("FAIL nw_addr_stable: got %h expected 100", imem.imem_addr); end
        @(negedge clk);
        jump = 1'b0; #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL nw_discard: got %b expected 0", fetch_valid); end
        @(negedge clk);
        wait_cycles = 0; #1;
        n_checks++; if (imem.imem_addr !== 32'h500 || instruction_if !== 32'h5A0) begin n_fail++; $display("FAIL nw_target: addr %h instr %h expected 500 5a0", imem.imem_addr, instruction_if); end
        @(negedge clk);
    endtask

    task automatic test_jump_priority();
        apply_reset(0);
        jump = 1'b1; jump_target = 32'h300; pcsrc = 1'b1; branch_target = 32'h200; #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jp_discard: got %b expected 0", fetch_valid); end
        @(negedge clk);
        jump = 1'b0; pcsrc = 1'b0; #1;
        n_checks++; if (imem.imem_addr !== 32'h300 || instruction_if !== 32'h3A0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL jp_target: addr %h instr %h valid %b expected 300 3a0 1", imem.imem_addr, instruction_if, fetch_valid); end
        @(negedge clk);
        jump = 1'b1; jump_target = 32'h303; #1;
        n_checks++; if (imem.imem_addr !== 32'h304 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jp_unaligned_pulse: addr %h valid %b expected 304 0", imem.imem_addr, fetch_valid); end
        @(negedge clk);
        jump = 1'b0; #1;
        n_checks++; if (imem.imem_addr !== 32'h300) begin n_fail++; $display("FAIL jp_unaligned_addr: got %h expected 300", imem.imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_ready_redirect();
        apply_reset(0);
        pc_write = 1'b0; #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rr_capture: got %b expected 0", fetch_valid); end
        @(negedge clk);
        pcsrc = 1'b1; branch_target = 32'h20E; #1;
        n_checks++; if (instruction_if !== 32'h1A0 || pc_sumado_if !== 32'h104) begin n_fail++; $display("FAIL rr_ready: got %h/%h expected 1a0/104", instruction_if, pc_sumado_if); end
        @(negedge clk);
        pcsrc = 1'b0; pc_write = 1'b1; #1;
        n_checks++; if (imem.imem_addr !== 32'h20C || instruction_if !== 32'h2AC) begin n_fail++; $display("FAIL rr_target: addr %h instr %h expected 20c 2ac", imem.imem_addr, instruction_if); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_request();
        apply_reset(0);
        repeat (2) @(negedge clk);
        wait_cycles = 2; #1;
        n_checks++; if (imem.imem_addr !== 32'h108 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rm_waiting: addr %h valid %b expected 108 0", imem.imem_addr, fetch_valid); end
        @(negedge clk);
        reset = 1'b1; force_ack = 1'b1; #1;
        n_checks++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rm_reset_port: req %b addr %h expected 0 100", imem.imem_req, imem.imem_addr); end
        n_checks++; if (fetch_valid !== 1'b0 || instruction_if !== 32'h0 || pc_sumado_if !== 32'h0) begin n_fail++; $display("FAIL rm_reset_out: %b/%h/%h expected 0/0/0", fetch_valid, instruction_if, pc_sumado_if); end
        repeat (2) @(negedge clk);
        reset = 1'b0; force_ack = 1'b0; wait_cycles = 0; #1;
        n_checks++; if (imem.imem_addr !== 32'h100 || imem.imem_req !== 1'b1 || instruction_if !== 32'h1A0) begin n_fail++; $display("FAIL rm_restart: addr %h req %b instr %h expected 100 1 1a0", imem.imem_addr, imem.imem_req, instruction_if); end
        @(negedge clk); #1;
        n_checks++; if (imem.imem_addr !== 32'h104) begin n_fail++; $display("FAIL rm_next: got %h expected 104", imem.imem_addr); end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; wait_cnt = 0;
        reset = 1'b1; pc_write = 1'b1; pcsrc = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; wait_cycles = 0; force_ack = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_newest_wins();
        test_jump_priority();
        test_ready_redirect();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within budget");
        $fatal(1, "timeout");
    end

endmodule
